// File: rtl/coffee_alert_pkg.sv
// Shared alert codes, FSM encodings and flag bit indices for the coffee machine
// error path (error handler, alert sequencer, LCD formatter).
package coffee_alert_pkg;

    localparam int unsigned NUM_FLAGS = 6;

    typedef logic [1:0] seq_state_t;
    localparam seq_state_t StIdle   = 2'd0;
    localparam seq_state_t StSelect = 2'd1;
    localparam seq_state_t StLoad   = 2'd2;
    localparam seq_state_t StDwell  = 2'd3;

    localparam logic [3:0] ALERT_NONE      = 4'd0;
    localparam logic [3:0] ALERT_ERR_BASE  = 4'd1;
    localparam logic [3:0] ALERT_WARN_BASE = 4'd7;

    localparam int unsigned ERR_NO_WATER       = 0;
    localparam int unsigned ERR_NO_PAPER       = 1;
    localparam int unsigned ERR_NO_COFFEE      = 2;
    localparam int unsigned ERR_TEMP_FAULT     = 3;
    localparam int unsigned ERR_PRESSURE_FAULT = 4;
    localparam int unsigned ERR_SYSTEM_FAULT   = 5;

    localparam int unsigned WARN_PAPER_LOW     = 0;
    localparam int unsigned WARN_BIN0_LOW      = 1;
    localparam int unsigned WARN_BIN1_LOW      = 2;
    localparam int unsigned WARN_CREAMER_LOW   = 3;
    localparam int unsigned WARN_CHOCOLATE_LOW = 4;
    localparam int unsigned WARN_TEMP_HEATING  = 5;

    function automatic logic [3:0] popcount6(input logic [5:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 6; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rr_pick6.sv
// Combinational round-robin picker: first set request at or after start, wrapping
// bit5 -> bit0. Out-of-range start pointers are treated as bit0.
module rr_pick6 (
    input  logic [5:0] req,
    input  logic [2:0] start,
    output logic       found,
    output logic [2:0] idx
);
    import coffee_alert_pkg::*;

    logic [3:0] base;
    logic [3:0] pos;

    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        pos   = 4'd0;
        base  = (start > 3'd5) ? 4'd0 : {1'b0, start};
        // Walk from the farthest candidate back so the nearest hit wins.
        for (int i = 5; i >= 0; i--) begin
            pos = base + 4'(i);
            if (pos >= 4'(NUM_FLAGS)) begin
                pos = pos - 4'(NUM_FLAGS);
            end
            if (req[pos[2:0]]) begin
                found = 1'b1;
                idx   = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/alert_sequencer.sv
// Time-shares the front-panel display among active errors (priority) and warnings,
// rotating round-robin with a fixed dwell, and pulses the buzzer on critical errors.
module alert_sequencer #(
    parameter logic [31:0] DWELL_CYCLES = 32'd100_000_000,
    parameter logic [31:0] BEEP_CYCLES  = 32'd12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] err_flags,
    input  logic [5:0] warn_flags,
    input  logic       critical_error,
    input  logic       ack_pulse,
    input  logic       display_ready,
    output logic       alert_load,
    output logic [3:0] alert_code,
    output logic       alert_valid,
    output logic       alert_is_error,
    output logic       beep,
    output logic [3:0] active_count
);
    import coffee_alert_pkg::*;

    localparam logic [31:0] DwellLast = DWELL_CYCLES - 32'd1;

    seq_state_t  state_q, state_d;
    logic [2:0]  last_ptr_q, last_ptr_d;
    logic [31:0] dwell_cnt_q, dwell_cnt_d;
    logic [31:0] beep_cnt_q, beep_cnt_d;
    logic        crit_q;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        is_err_q, is_err_d;
    logic [3:0]  count_q;

    logic       err_any, warn_any;
    logic       err_found, warn_found;
    logic [2:0] err_idx, warn_idx;
    logic [2:0] next_ptr, err_start, warn_start;
    logic       shown_flag, leave_dwell;

    assign err_any  = |err_flags;
    assign warn_any = |warn_flags;
    assign next_ptr = (last_ptr_q >= 3'd5) ? 3'd0 : last_ptr_q + 3'd1;

    // Continue after the last shown bit only when staying in the same class.
    assign err_start  = (valid_q && is_err_q)  ? next_ptr : 3'd0;
    assign warn_start = (valid_q && !is_err_q) ? next_ptr : 3'd0;

    rr_pick6 u_err_pick (
        .req   (err_flags),
        .start (err_start),
        .found (err_found),
        .idx   (err_idx)
    );

    rr_pick6 u_warn_pick (
        .req   (warn_flags),
        .start (warn_start),
        .found (warn_found),
        .idx   (warn_idx)
    );

    assign shown_flag  = is_err_q ? err_flags[last_ptr_q] : warn_flags[last_ptr_q];
    assign leave_dwell = (dwell_cnt_q == DwellLast) || ack_pulse || !shown_flag ||
                         (!is_err_q && err_any);

    always_comb begin
        state_d     = state_q;
        last_ptr_d  = last_ptr_q;
        dwell_cnt_d = dwell_cnt_q;
        code_d      = code_q;
        valid_d     = valid_q;
        is_err_d    = is_err_q;
        unique case (state_q)
            StIdle: begin
                if (err_any || warn_any) begin
                    state_d = StSelect;
                end
            end
            StSelect: begin
                if (err_any && err_found) begin
                    state_d    = StLoad;
                    code_d     = ALERT_ERR_BASE + {1'b0, err_idx};
                    valid_d    = 1'b1;
                    is_err_d   = 1'b1;
                    last_ptr_d = err_idx;
                end else if (warn_found) begin
                    state_d    = StLoad;
                    code_d     = ALERT_WARN_BASE + {1'b0, warn_idx};
                    valid_d    = 1'b1;
                    is_err_d   = 1'b0;
                    last_ptr_d = warn_idx;
                end else begin
                    state_d  = StIdle;
                    code_d   = ALERT_NONE;
                    valid_d  = 1'b0;
                    is_err_d = 1'b0;
                end
            end
            StLoad: begin
                if (display_ready) begin
                    state_d     = StDwell;
                    dwell_cnt_d = 32'd0;
                end
            end
            StDwell: begin
                if (dwell_cnt_q != DwellLast) begin
                    dwell_cnt_d = dwell_cnt_q + 32'd1;
                end
                if (leave_dwell) begin
                    state_d = StSelect;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A fresh critical edge outranks a simultaneous acknowledge.
    always_comb begin
        beep_cnt_d = beep_cnt_q;
        if (critical_error && !crit_q) begin
            beep_cnt_d = BEEP_CYCLES;
        end else if (ack_pulse) begin
            beep_cnt_d = 32'd0;
        end else if (beep_cnt_q != 32'd0) begin
            beep_cnt_d = beep_cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            last_ptr_q  <= 3'd0;
            dwell_cnt_q <= 32'd0;
            beep_cnt_q  <= 32'd0;
            crit_q      <= 1'b0;
            code_q      <= ALERT_NONE;
            valid_q     <= 1'b0;
            is_err_q    <= 1'b0;
            count_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            last_ptr_q  <= last_ptr_d;
            dwell_cnt_q <= dwell_cnt_d;
            beep_cnt_q  <= beep_cnt_d;
            crit_q      <= critical_error;
            code_q      <= code_d;
            valid_q     <= valid_d;
            is_err_q    <= is_err_d;
            count_q     <= popcount6(err_flags) + popcount6(warn_flags);
        end
    end

    assign alert_load     = (state_q == StLoad);
    assign alert_code     = code_q;
    assign alert_valid    = valid_q;
    assign alert_is_error = is_err_q;
    assign beep           = (beep_cnt_q != 32'd0);
    assign active_count   = count_q;

endmodule

// File: tb/tb_alert_sequencer.sv
// Directed bench for alert_sequencer with DWELL_CYCLES = 8 and BEEP_CYCLES = 4.
module tb_alert_sequencer;

    logic       clk;
    logic       rst_n;
    logic [5:0] err_flags;
    logic [5:0] warn_flags;
    logic       critical_error;
    logic       ack_pulse;
    logic       display_ready;
    logic       alert_load;
    logic [3:0] alert_code;
    logic       alert_valid;
    logic       alert_is_error;
    logic       beep;
    logic [3:0] active_count;

    int tests;
    int failures;

    alert_sequencer #(
        .DWELL_CYCLES (32'd8),
        .BEEP_CYCLES  (32'd4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .err_flags      (err_flags),
        .warn_flags     (warn_flags),
        .critical_error (critical_error),
        .ack_pulse      (ack_pulse),
        .display_ready  (display_ready),
        .alert_load     (alert_load),
        .alert_code     (alert_code),
        .alert_valid    (alert_valid),
        .alert_is_error (alert_is_error),
        .beep           (beep),
        .active_count   (active_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] err;
        logic       rdy;
        int         cycles;
        logic       load;
        logic [3:0] code;
        logic       valid;
        logic       is_err;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input string name, input logic [5:0] err, input logic rdy,
                                input int cycles, input logic load, input logic [3:0] code,
                                input logic valid, input logic is_err, input logic [3:0] cnt);
        vec_t v;
        v.name   = name;
        v.err    = err;
        v.rdy    = rdy;
        v.cycles = cycles;
        v.load   = load;
        v.code   = code;
        v.valid  = valid;
        v.is_err = is_err;
        v.cnt    = cnt;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic load, input logic [3:0] code,
                              input logic valid, input logic is_err, input logic bp,
                              input logic [3:0] cnt);
        check({tag, ".load"},   32'(alert_load),     32'(load));
        check({tag, ".code"},   32'(alert_code),     32'(code));
        check({tag, ".valid"},  32'(alert_valid),    32'(valid));
        check({tag, ".is_err"}, 32'(alert_is_error), 32'(is_err));
        check({tag, ".beep"},   32'(beep),           32'(bp));
        check({tag, ".count"},  32'(active_count),   32'(cnt));
    endtask

    task automatic do_reset;
        rst_n          = 1'b0;
        err_flags      = 6'd0;
        warn_flags     = 6'd0;
        critical_error = 1'b0;
        ack_pulse      = 1'b0;
        display_ready  = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        tests    = 0;
        failures = 0;

        // Errors 0 and 2 alternate; an 8-cycle dwell puts LOAD exactly 10 edges apart.
        vecs[0]  = mk("rr_select1",     6'b000101, 1'b1, 1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2);
        vecs[1]  = mk("rr_load_c1",     6'b000101, 1'b1, 1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd2);
        vecs[2]  = mk("rr_dwell_c1",    6'b000101, 1'b1, 1, 1'b0, 4'd1, 1'b1, 1'b1, 4'd2);
        vecs[3]  = mk("rr_dwell_c1_end", 6'b000101, 1'b1, 7, 1'b0, 4'd1, 1'b1, 1'b1, 4'd2);
        vecs[4]  = mk("rr_select2",     6'b000101, 1'b1, 1, 1'b0, 4'd1, 1'b1, 1'b1, 4'd2);
        vecs[5]  = mk("rr_load_c3",     6'b000101, 1'b1, 1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd2);
        vecs[6]  = mk("rr_dwell_c3",    6'b000101, 1'b1, 1, 1'b0, 4'd3, 1'b1, 1'b1, 4'd2);
        vecs[7]  = mk("rr_dwell_c3_end", 6'b000101, 1'b1, 7, 1'b0, 4'd3, 1'b1, 1'b1, 4'd2);
        vecs[8]  = mk("rr_select3",     6'b000101, 1'b1, 1, 1'b0, 4'd3, 1'b1, 1'b1, 4'd2);
        vecs[9]  = mk("rr_load_c1_again", 6'b000101, 1'b1, 1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd2);
        // Flags drop during LOAD: transfer still happens, then DWELL notices the loss.
        vecs[10] = mk("clr_dwell",      6'b000000, 1'b1, 1, 1'b0, 4'd1, 1'b1, 1'b1, 4'd0);
        vecs[11] = mk("clr_select",     6'b000000, 1'b1, 1, 1'b0, 4'd1, 1'b1, 1'b1, 4'd0);
        vecs[12] = mk("clr_idle",       6'b000000, 1'b1, 1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
        vecs[13] = mk("clr_idle_hold",  6'b000000, 1'b1, 3, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);

        rst_n          = 1'b0;
        err_flags      = 6'd0;
        warn_flags     = 6'd0;
        critical_error = 1'b0;
        ack_pulse      = 1'b0;
        display_ready  = 1'b0;
        tick(3);
        rst_n = 1'b1;
        check_outs("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);

        for (int i = 0; i < 14; i++) begin
            err_flags     = vecs[i].err;
            display_ready = vecs[i].rdy;
            tick(vecs[i].cycles);
            check_outs(vecs[i].name, vecs[i].load, vecs[i].code, vecs[i].valid,
                       vecs[i].is_err, 1'b0, vecs[i].cnt);
        end

        // Warning preempted by an error mid-dwell.
        do_reset();
        warn_flags    = 6'b000001;
        display_ready = 1'b1;
        tick(2);
        check_outs("pre_load_w7", 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 4'd1);
        tick(2);
        err_flags = 6'b100000;
        tick(1);
        check_outs("pre_select", 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 4'd2);
        tick(1);
        check_outs("pre_load_e6", 1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 4'd2);

        // ack ignored in LOAD, honoured in the second DWELL cycle.
        do_reset();
        warn_flags = 6'b100010;
        tick(2);
        check_outs("ack_load_w8", 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 4'd2);
        ack_pulse = 1'b1;
        tick(1);
        ack_pulse = 1'b0;
        check_outs("ack_in_load", 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 4'd2);
        display_ready = 1'b1;
        tick(1);
        check("ack_dwell.load", 32'(alert_load), 32'd0);
        tick(1);
        ack_pulse = 1'b1;
        tick(1);
        ack_pulse = 1'b0;
        check("ack_select.load", 32'(alert_load), 32'd0);
        tick(1);
        check_outs("ack_load_w12", 1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 4'd2);

        // display_ready low for 5 LOAD cycles; single alert reloads after the dwell.
        do_reset();
        err_flags = 6'b000010;
        tick(2);
        check_outs("rdy_load", 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check_outs("rdy_hold", 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd1);
        end
        display_ready = 1'b1;
        tick(1);
        check("rdy_dwell.load", 32'(alert_load), 32'd0);
        tick(7);
        check("rdy_dwell_end.load", 32'(alert_load), 32'd0);
        tick(1);
        check("rdy_select.load", 32'(alert_load), 32'd0);
        tick(1);
        check_outs("rdy_reload", 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd1);

        // Beep length, restart on a new rise, and clear on ack.
        do_reset();
        critical_error = 1'b1;
        tick(1);
        check("beep_c1", 32'(beep), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("beep_hold", 32'(beep), 32'd1);
        end
        tick(1);
        check("beep_end", 32'(beep), 32'd0);
        critical_error = 1'b0;
        tick(1);
        critical_error = 1'b1;
        tick(1);
        check("beep2_c1", 32'(beep), 32'd1);
        critical_error = 1'b0;
        tick(1);
        check("beep2_c2", 32'(beep), 32'd1);
        critical_error = 1'b1;
        tick(1);
        check("beep2_restart", 32'(beep), 32'd1);
        tick(2);
        check("beep2_extended", 32'(beep), 32'd1);
        tick(1);
        check("beep2_last", 32'(beep), 32'd1);
        tick(1);
        check("beep2_end", 32'(beep), 32'd0);
        critical_error = 1'b0;
        tick(1);
        critical_error = 1'b1;
        tick(1);
        check("beep3_on", 32'(beep), 32'd1);
        ack_pulse = 1'b1;
        tick(1);
        ack_pulse = 1'b0;
        check("beep3_ack", 32'(beep), 32'd0);

        // Asynchronous reset in the middle of LOAD and a beep.
        do_reset();
        err_flags      = 6'b000001;
        critical_error = 1'b1;
        tick(2);
        check_outs("rst_pre", 1'b1, 4'd1, 1'b1, 1'b1, 1'b1, 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rst_async", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick(1);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/alert_sequencer.md
# alert_sequencer

Time-shares the front-panel display among all active error and warning flags from the error handler. Active errors always take priority over warnings. Alerts within a class rotate round-robin, each held for a fixed dwell time or until the user acknowledges it. The block sits between the error handler outputs and the LCD message formatter, and also drives the buzzer on each new critical error.

## Interface
- DWELL_CYCLES, 32'd100_000_000, hold time per alert (2 s at 50 MHz); must be ≥ 1
- BEEP_CYCLES, 32'd12_500_000, buzzer pulse length (250 ms); must be ≥ 1

- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- err_flags  in  6  bit0 no_water, bit1 no_paper, bit2 no_coffee, bit3 temp_fault, bit4 pressure_fault, bit5 system_fault
- warn_flags  in  6  bit0 paper_low, bit1 bin0_low, bit2 bin1_low, bit3 creamer_low, bit4 chocolate_low, bit5 temp_heating
- critical_error  in  1  level from error handler
- ack_pulse  in  1  one-cycle debounced user acknowledge
- display_ready  in  1  formatter can accept a new code
- alert_load  out  1  request to formatter; held until display_ready
- alert_code  out  4  0 = none; 1–6 = error bit+1; 7–12 = warning bit+7
- alert_valid  out  1  alert_code is a live alert
- alert_is_error  out  1  alert_code is in 1–6
- beep  out  1  buzzer enable
- active_count  out  4  registered popcount of err_flags and warn_flags, 0–12

## Operation
- FSM states are IDLE, SELECT, LOAD and DWELL.
- IDLE:
  - alert_valid = 0, alert_code = 0.
  - If any flag is set, go to SELECT.
- SELECT (one cycle):
  - If any err_flags bit is set, pick the next set error bit strictly after last_ptr, wrapping through bit5→bit0.
  - Otherwise, pick the next set warning bit the same way.
  - last_ptr is a 3-bit index of the last shown bit. On a class change, the search starts from bit0.
  - If nothing is set: alert_code = 0, alert_valid = 0, alert_is_error = 0, then go to IDLE.
- LOAD:
  - alert_code, alert_valid and alert_is_error are updated on entry and stay stable until the next LOAD or IDLE.
  - alert_load = 1 throughout LOAD.
  - Transfer happens on a cycle where alert_load and display_ready are both high. On transfer, go to DWELL and clear the dwell counter.
  - ack_pulse is ignored in LOAD.
- DWELL: the counter increments each cycle. Leave for SELECT on the earliest of these events:
  - the counter reaches DWELL_CYCLES-1;
  - ack_pulse arrives;
  - the shown flag deasserts;
  - a warning is shown and any error bit asserts (preemption).
  - Several events in the same cycle cause exactly one advance.
- A single active alert is re-selected and reloaded after each dwell; alert_code itself does not change.
- Beep:
  - A rising edge of critical_error (compared with a registered copy) loads the beep counter with BEEP_CYCLES.
  - beep = 1 while the counter is nonzero.
  - A new rising edge during a beep restarts the count.
  - ack_pulse clears the counter.
- active_count is registered every cycle and is independent of the FSM.

## Timing
- Reset: all outputs 0, state IDLE, last_ptr 0, counters 0, previous critical_error 0.
- Reset is honoured in any state, including mid-LOAD and mid-beep.
- Flag rises at edge N while in IDLE:
  - edge N+1: SELECT;
  - edge N+2: LOAD, with the code and alert_load visible;
  - if display_ready is already high, edge N+3: DWELL.
- Dwell is exactly DWELL_CYCLES cycles in DWELL, then one SELECT cycle plus at least one LOAD cycle.
- ack_pulse in DWELL at edge M gives SELECT at M+1.
- beep rises one cycle after critical_error rises and lasts BEEP_CYCLES cycles.
- active_count lags the flags by one cycle.
- Counters are 32-bit unsigned with no wrap in normal use. The dwell counter saturates at DWELL_CYCLES-1.

## Structure
- Package coffee_alert_pkg holds:
  - the FSM state enum;
  - alert code constants ALERT_NONE, ALERT_ERR_BASE = 1 and ALERT_WARN_BASE = 7;
  - error and warning bit-index localparams shared with the error handler and the LCD formatter.
- Sub-module rr_pick6 is combinational: 6-bit request plus 3-bit start pointer in, found flag plus 3-bit index out. It is instantiated once for errors and once for warnings.

## Test plan
All scenarios use DWELL_CYCLES = 8 and BEEP_CYCLES = 4.
- err_flags = 6'b000101, display_ready = 1 → codes 1, 3, 1, 3…, each DWELL lasting 8 cycles, alert_is_error = 1.
- Warning 7 showing, then err_flags bit5 set mid-dwell → SELECT the next cycle, then code 6 with alert_is_error = 1.
- warn_flags = 6'b100010, ack_pulse in cycle 2 of DWELL → immediate advance from 8 to 12; ack_pulse during LOAD is ignored.
- display_ready held low for 5 cycles in LOAD → alert_load stays high with code stable, and DWELL starts the cycle after display_ready rises.
- critical_error rises → beep high for exactly 4 cycles; a second rise at beep cycle 2 extends it to 4 cycles from that point; ack_pulse drops it the next cycle.
- All flags cleared while in DWELL → SELECT then IDLE, alert_code = 0, alert_valid = 0, active_count = 0. Asserting rst_n low mid-LOAD zeroes all outputs immediately.
